axis_frame_gen: RTL

AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

---
 rtl/axis_frame_pkg.sv | 24 ++
 rtl/axis_frame_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_pkg.sv
// Shared types and helpers for the AXI-Stream frame generator and its length monitor.
// Holds the FSM state type, the beat byte-lane count and the keep-mask builder.
package axis_frame_pkg;

    localparam int unsigned KEEP_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Contiguous byte-enable mask with the low nb bits set.
    function automatic logic [KEEP_WIDTH-1:0] keep_from_bytes(input logic [3:0] nb);
        logic [KEEP_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (i < int'(nb)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: emits a frame of cmd_len incrementing bytes per command,
// with registered stream outputs and per-frame completion reporting.
module axis_frame_gen #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [LEN_WIDTH-1:0]  tx_len,
    output logic                  tx_done,
    output logic                  zero_len_err,
    output logic [31:0]           frame_count
);

    import axis_frame_pkg::*;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_reg_q, len_reg_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]  offset_q, offset_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [LEN_WIDTH-1:0]  tx_len_q, tx_len_d;
    logic                  tx_done_q, tx_done_d;
    logic                  zero_len_err_q, zero_len_err_d;
    logic [31:0]           frame_count_q, frame_count_d;

    logic                  accept;
    logic                  handshake;
    logic [3:0]            nb_cur;
    logic [LEN_WIDTH-1:0]  rem_after;
    logic [LEN_WIDTH-1:0]  beat_rem;
    logic [LEN_WIDTH-1:0]  beat_off;
    logic [3:0]            beat_nb;
    logic [KEEP_WIDTH-1:0] beat_keep;
    logic                  beat_last;
    logic [DATA_WIDTH-1:0] beat_data;

    assign accept    = cmd_valid & cmd_ready;
    assign handshake = tvalid_q & m_axis_tready;

    // Byte count of the beat currently presented on the bus.
    always_comb begin
        nb_cur = 4'(KEEP_WIDTH);
        if (remaining_q < LEN_WIDTH'(KEEP_WIDTH)) begin
            nb_cur = remaining_q[3:0];
        end
        rem_after = remaining_q - LEN_WIDTH'(nb_cur);
    end

    // Next beat contents: first beat of a new command, or the beat after the current one.
    always_comb begin
        beat_rem = rem_after;
        beat_off = offset_q + LEN_WIDTH'(KEEP_WIDTH);
        if (state_q == IDLE) begin
            beat_rem = cmd_len;
            beat_off = '0;
        end
        beat_nb = 4'(KEEP_WIDTH);
        if (beat_rem < LEN_WIDTH'(KEEP_WIDTH)) begin
            beat_nb = beat_rem[3:0];
        end
        beat_keep = keep_from_bytes(beat_nb);
        beat_last = (beat_rem <= LEN_WIDTH'(KEEP_WIDTH));
        beat_data = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (beat_keep[i]) begin
                beat_data[8*i +: 8] = beat_off[7:0] + 8'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && (cmd_len != '0)) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (handshake && tlast_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        cmd_ready = (state_q == IDLE);
    end

    // Datapath next-state.
    always_comb begin
        len_reg_d      = len_reg_q;
        remaining_d    = remaining_q;
        offset_d       = offset_q;
        tvalid_d       = tvalid_q;
        tlast_d        = tlast_q;
        tkeep_d        = tkeep_q;
        tdata_d        = tdata_q;
        tx_len_d       = tx_len_q;
        tx_done_d      = 1'b0;
        zero_len_err_d = 1'b0;
        frame_count_d  = frame_count_q;

        if (accept) begin
            len_reg_d   = cmd_len;
            remaining_d = cmd_len;
            offset_d    = '0;
            if (cmd_len == '0) begin
                zero_len_err_d = 1'b1;
            end else begin
                tvalid_d = 1'b1;
                tlast_d  = beat_last;
                tkeep_d  = beat_keep;
                tdata_d  = beat_data;
            end
        end else if (handshake) begin
            remaining_d = rem_after;
            if (tlast_q) begin
                tvalid_d      = 1'b0;
                tlast_d       = 1'b0;
                tkeep_d       = '0;
                tdata_d       = '0;
                tx_len_d      = len_reg_q;
                tx_done_d     = 1'b1;
                frame_count_d = frame_count_q + 32'd1;
            end else begin
                offset_d = beat_off;
                tvalid_d = 1'b1;
                tlast_d  = beat_last;
                tkeep_d  = beat_keep;
                tdata_d  = beat_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg_q      <= '0;
            remaining_q    <= '0;
            offset_q       <= '0;
            tvalid_q       <= 1'b0;
            tlast_q        <= 1'b0;
            tkeep_q        <= '0;
            tdata_q        <= '0;
            tx_len_q       <= '0;
            tx_done_q      <= 1'b0;
            zero_len_err_q <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            len_reg_q      <= len_reg_d;
            remaining_q    <= remaining_d;
            offset_q       <= offset_d;
            tvalid_q       <= tvalid_d;
            tlast_q        <= tlast_d;
            tkeep_q        <= tkeep_d;
            tdata_q        <= tdata_d;
            tx_len_q       <= tx_len_d;
            tx_done_q      <= tx_done_d;
            zero_len_err_q <= zero_len_err_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tdata  = tdata_q;
    assign tx_len        = tx_len_q;
    assign tx_done       = tx_done_q;
    assign zero_len_err  = zero_len_err_q;
    assign frame_count   = frame_count_q;

endmodule
